// File: rtl/posi_md_ram_arb.sv
// Port arbiter for the 64x6 position/mode RAM: one writer, two readers and an LCU-start clear sweep.
// Optional macro POSI_MD_ARB_RR_EN: round-robin between the readers (default: rd0 > rd1).
module posi_md_ram_arb #(
    parameter int ADR_WD = 6,
    parameter int ADR    = 64,
    parameter int DAT_WD = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_start_i,
    input  logic [DAT_WD-1:0] clr_val_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    input  logic              wr_req_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    output logic              wr_ack_o,
    input  logic              rd0_req_i,
    input  logic [ADR_WD-1:0] rd0_adr_i,
    output logic              rd0_ack_o,
    output logic              rd0_vld_o,
    output logic [DAT_WD-1:0] rd0_dat_o,
    input  logic              rd1_req_i,
    input  logic [ADR_WD-1:0] rd1_adr_i,
    output logic              rd1_ack_o,
    output logic              rd1_vld_o,
    output logic [DAT_WD-1:0] rd1_dat_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i,
    output logic              dbg_state_o
);

    typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

    localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(ADR - 1);

    state_t            r_state;
    logic [ADR_WD-1:0] r_clr_cnt;
    logic [DAT_WD-1:0] r_clr_val;
    logic              r_clr_done;
    logic [1:0]        r_rd_pend;
    logic [DAT_WD-1:0] r_rd0_hold;
    logic [DAT_WD-1:0] r_rd1_hold;

    logic w_idle;
    logic w_wr_gnt;
    logic w_rd_ok;
    logic w_rd0_gnt;
    logic w_rd1_gnt;

    // Handshake: a requester holds req and its address/data stable until ack; ack is
    // combinational in the same cycle and means the access was issued (consumed) then.
    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_gnt = w_idle & wr_req_i;
    assign w_rd_ok  = w_idle & ~wr_req_i;

`ifdef POSI_MD_ARB_RR_EN
    logic r_rr_ptr;  // 0: rd0 wins a tie, 1: rd1 wins a tie

    assign w_rd0_gnt = w_rd_ok & rd0_req_i & (~rd1_req_i | ~r_rr_ptr);
    assign w_rd1_gnt = w_rd_ok & rd1_req_i & (~rd0_req_i |  r_rr_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 1'b0;
        end else if (w_rd0_gnt) begin
            r_rr_ptr <= 1'b1;
        end else if (w_rd1_gnt) begin
            r_rr_ptr <= 1'b0;
        end
    end
`else
    assign w_rd0_gnt = w_rd_ok & rd0_req_i;
    assign w_rd1_gnt = w_rd_ok & rd1_req_i & ~rd0_req_i;
`endif

    assign wr_ack_o    = w_wr_gnt;
    assign rd0_ack_o   = w_rd0_gnt;
    assign rd1_ack_o   = w_rd1_gnt;
    assign clr_busy_o  = (r_state == S_CLEAR);
    assign clr_done_o  = r_clr_done;
    assign dbg_state_o = (r_state == S_CLEAR);

    always_comb begin
        ram_adr_o    = '0;
        ram_wr_ena_o = 1'b1;
        ram_wr_dat_o = '0;
        ram_rd_ena_o = 1'b1;
        if (r_state == S_CLEAR) begin
            ram_wr_ena_o = 1'b0;
            ram_adr_o    = r_clr_cnt;
            ram_wr_dat_o = r_clr_val;
        end else if (w_wr_gnt) begin
            ram_wr_ena_o = 1'b0;
            ram_adr_o    = wr_adr_i;
            ram_wr_dat_o = wr_dat_i;
        end else if (w_rd0_gnt) begin
            ram_rd_ena_o = 1'b0;
            ram_adr_o    = rd0_adr_i;
        end else if (w_rd1_gnt) begin
            ram_rd_ena_o = 1'b0;
            ram_adr_o    = rd1_adr_i;
        end
    end

    // Read data arrives one cycle after the grant; pass it through that cycle, then hold it.
    assign rd0_vld_o = r_rd_pend[0];
    assign rd1_vld_o = r_rd_pend[1];
    assign rd0_dat_o = r_rd_pend[0] ? ram_rd_dat_i : r_rd0_hold;
    assign rd1_dat_o = r_rd_pend[1] ? ram_rd_dat_i : r_rd1_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_clr_cnt  <= '0;
            r_clr_val  <= '0;
            r_clr_done <= 1'b0;
            r_rd_pend  <= 2'b00;
            r_rd0_hold <= '0;
            r_rd1_hold <= '0;
        end else begin
            r_clr_done <= 1'b0;
            r_rd_pend  <= {w_rd1_gnt, w_rd0_gnt};
            if (r_rd_pend[0]) begin
                r_rd0_hold <= ram_rd_dat_i;
            end
            if (r_rd_pend[1]) begin
                r_rd1_hold <= ram_rd_dat_i;
            end
            case (r_state)
                S_IDLE: begin
                    if (clr_start_i) begin
                        r_state   <= S_CLEAR;
                        r_clr_val <= clr_val_i;
                        r_clr_cnt <= '0;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == LAST_ADR) begin
                        r_state    <= S_IDLE;
                        r_clr_cnt  <= '0;
                        r_clr_done <= 1'b1;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADR_WD'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_posi_md_ram_arb.sv
// Directed bench for posi_md_ram_arb with a behavioural single-port RAM attached.
// Honours POSI_MD_ARB_RR_EN for the reader-arbitration expectations.
module tb_posi_md_ram_arb;

`ifdef POSI_MD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       clr_start;
    logic [5:0] clr_val;
    logic       clr_busy;
    logic       clr_done;
    logic       wr_req;
    logic [5:0] wr_adr;
    logic [5:0] wr_dat;
    logic       wr_ack;
    logic       rd0_req;
    logic [5:0] rd0_adr;
    logic       rd0_ack;
    logic       rd0_vld;
    logic [5:0] rd0_dat;
    logic       rd1_req;
    logic [5:0] rd1_adr;
    logic       rd1_ack;
    logic       rd1_vld;
    logic [5:0] rd1_dat;
    logic [5:0] ram_adr;
    logic       ram_wr_ena;
    logic [5:0] ram_wr_dat;
    logic       ram_rd_ena;
    logic [5:0] ram_rd_q;
    logic       dbg_state;

    logic [5:0] mem [64];

    int n_checks = 0;
    int n_err    = 0;

    posi_md_ram_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr_start_i  (clr_start),
        .clr_val_i    (clr_val),
        .clr_busy_o   (clr_busy),
        .clr_done_o   (clr_done),
        .wr_req_i     (wr_req),
        .wr_adr_i     (wr_adr),
        .wr_dat_i     (wr_dat),
        .wr_ack_o     (wr_ack),
        .rd0_req_i    (rd0_req),
        .rd0_adr_i    (rd0_adr),
        .rd0_ack_o    (rd0_ack),
        .rd0_vld_o    (rd0_vld),
        .rd0_dat_o    (rd0_dat),
        .rd1_req_i    (rd1_req),
        .rd1_adr_i    (rd1_adr),
        .rd1_ack_o    (rd1_ack),
        .rd1_vld_o    (rd1_vld),
        .rd1_dat_o    (rd1_dat),
        .ram_adr_o    (ram_adr),
        .ram_wr_ena_o (ram_wr_ena),
        .ram_wr_dat_o (ram_wr_dat),
        .ram_rd_ena_o (ram_rd_ena),
        .ram_rd_dat_i (ram_rd_q),
        .dbg_state_o  (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM with low-active enables, read data one cycle later
    always @(posedge clk) begin
        if (!ram_wr_ena) mem[ram_adr] <= ram_wr_dat;
        if (!ram_rd_ena) ram_rd_q <= mem[ram_adr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 2 ns after the rising edge, outputs sampled 1 ns later.
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        clr_start = 1'b0;
        wr_req    = 1'b0;
        rd0_req   = 1'b0;
        rd1_req   = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        rst_n     = 1'b0;
        clr_val   = 6'h00;
        wr_adr    = 6'h00;
        wr_dat    = 6'h00;
        rd0_adr   = 6'h00;
        rd1_adr   = 6'h00;
        ram_rd_q  = 6'h00;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", clr_busy, 0);
        chk("rst_done", clr_done, 0);
        chk("rst_wr_ena", ram_wr_ena, 1);
        chk("rst_rd_ena", ram_rd_ena, 1);
        chk("rst_adr", ram_adr, 0);
        chk("rst_wr_dat", ram_wr_dat, 0);
        chk("rst_vld0", rd0_vld, 0);
        chk("rst_vld1", rd1_vld, 0);
        chk("rst_dat0", rd0_dat, 0);
        chk("rst_dat1", rd1_dat, 0);
        chk("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // 1. Clear sweep with 0x3F, then read back adr 0x2A on rd0
        next_cycle();
        clr_start = 1'b1;
        clr_val   = 6'h3F;
        #1;
        chk("t1_start_busy", clr_busy, 0);
        for (int i = 0; i < 64; i++) begin
            next_cycle();
            clr_start = 1'b0;
            clr_val   = 6'h00;
            #1;
            chk("t1_busy", clr_busy, 1);
            chk("t1_wr_ena", ram_wr_ena, 0);
            chk("t1_adr", ram_adr, i);
            chk("t1_wr_dat", ram_wr_dat, 6'h3F);
            chk("t1_done_early", clr_done, 0);
        end
        next_cycle();
        #1;
        chk("t1_done", clr_done, 1);
        chk("t1_busy_end", clr_busy, 0);
        chk("t1_wr_ena_end", ram_wr_ena, 1);
        next_cycle();
        #1;
        chk("t1_done_pulse", clr_done, 0);
        next_cycle();
        rd0_req = 1'b1;
        rd0_adr = 6'h2A;
        #1;
        chk("t1_rd0_ack", rd0_ack, 1);
        chk("t1_rd_ena", ram_rd_ena, 0);
        chk("t1_rd_adr", ram_adr, 6'h2A);
        next_cycle();
        rd0_req = 1'b0;
        #1;
        chk("t1_rd0_vld", rd0_vld, 1);
        chk("t1_rd0_dat", rd0_dat, 6'h3F);
        next_cycle();
        #1;
        chk("t1_rd0_vld_drop", rd0_vld, 0);
        chk("t1_rd0_dat_hold", rd0_dat, 6'h3F);

        // 6. Write adr 63 = 0x2A, then rd1 of adr 63
        next_cycle();
        wr_req = 1'b1;
        wr_adr = 6'd63;
        wr_dat = 6'h2A;
        #1;
        chk("t6_wr_ack", wr_ack, 1);
        chk("t6_wr_ena", ram_wr_ena, 0);
        chk("t6_wr_adr", ram_adr, 6'd63);
        chk("t6_wr_dat", ram_wr_dat, 6'h2A);
        chk("t6_rd_ena", ram_rd_ena, 1);
        next_cycle();
        wr_req  = 1'b0;
        rd1_req = 1'b1;
        rd1_adr = 6'd63;
        #1;
        chk("t6_rd1_ack", rd1_ack, 1);
        chk("t6_rd0_ack", rd0_ack, 0);
        chk("t6_rd1_adr", ram_adr, 6'd63);
        chk("t6_rd1_vld_early", rd1_vld, 0);
        next_cycle();
        rd1_req = 1'b0;
        #1;
        chk("t6_rd1_vld", rd1_vld, 1);
        chk("t6_rd1_dat", rd1_dat, 6'h2A);
        chk("t6_rd0_vld", rd0_vld, 0);
        chk("t6_rd0_dat_hold", rd0_dat, 6'h3F);

        // 2. Write adr 5 = 0x11 with rd0/rd1 of adr 5 in the same cycle
        next_cycle();
        wr_req  = 1'b1;
        wr_adr  = 6'd5;
        wr_dat  = 6'h11;
        rd0_req = 1'b1;
        rd0_adr = 6'd5;
        rd1_req = 1'b1;
        rd1_adr = 6'd5;
        #1;
        chk("t2_wr_ack", wr_ack, 1);
        chk("t2_rd0_ack_c0", rd0_ack, 0);
        chk("t2_rd1_ack_c0", rd1_ack, 0);
        next_cycle();
        wr_req = 1'b0;
        #1;
        chk("t2_rd0_ack_c1", rd0_ack, 1);
        chk("t2_rd1_ack_c1", rd1_ack, 0);
        next_cycle();
        rd0_req = 1'b0;
        #1;
        chk("t2_rd1_ack_c2", rd1_ack, 1);
        chk("t2_rd0_vld", rd0_vld, 1);
        chk("t2_rd0_dat", rd0_dat, 6'h11);
        next_cycle();
        rd1_req = 1'b0;
        #1;
        chk("t2_rd1_vld", rd1_vld, 1);
        chk("t2_rd1_dat", rd1_dat, 6'h11);
        chk("t2_rd0_vld_drop", rd0_vld, 0);

        // 3. rd0 (adr 5) and rd1 (adr 63) held together for 6 cycles
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            rd0_req = 1'b1;
            rd0_adr = 6'd5;
            rd1_req = 1'b1;
            rd1_adr = 6'd63;
            #1;
            chk("t3_rd0_ack", rd0_ack, RR ? ((i % 2) == 0) : 1);
            chk("t3_rd1_ack", rd1_ack, RR ? ((i % 2) == 1) : 0);
            if (i > 0) begin
                chk("t3_rd0_vld", rd0_vld, RR ? ((i % 2) == 1) : 1);
                chk("t3_rd0_dat", rd0_dat, 6'h11);
            end
        end
        next_cycle();
        rd0_req = 1'b0;
        #1;
        chk("t3_rd1_ack_alone", rd1_ack, 1);
        chk("t3_rd0_ack_alone", rd0_ack, 0);
        next_cycle();
        rd1_req = 1'b0;
        #1;
        chk("t3_rd1_vld", rd1_vld, 1);
        chk("t3_rd1_dat", rd1_dat, 6'h2A);

        // 4. Requests held across a clear sweep; mid-sweep clr_start must be ignored
        next_cycle();
        clr_start = 1'b1;
        clr_val   = 6'h15;
        #1;
        next_cycle();
        clr_start = 1'b0;
        wr_req    = 1'b1;
        wr_adr    = 6'd7;
        wr_dat    = 6'h22;
        rd0_req   = 1'b1;
        rd0_adr   = 6'd9;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) next_cycle();
            clr_start = (i == 10);
            #1;
            chk("t4_wr_ack", wr_ack, 0);
            chk("t4_rd0_ack", rd0_ack, 0);
            chk("t4_adr", ram_adr, i);
            chk("t4_wr_dat", ram_wr_dat, 6'h15);
        end
        next_cycle();
        clr_start = 1'b0;
        #1;
        chk("t4_done", clr_done, 1);
        chk("t4_first_wr_ack", wr_ack, 1);
        chk("t4_first_rd0_ack", rd0_ack, 0);
        next_cycle();
        wr_req = 1'b0;
        #1;
        chk("t4_rd0_ack", rd0_ack, 1);
        chk("t4_done_pulse", clr_done, 0);
        next_cycle();
        rd0_req = 1'b0;
        #1;
        chk("t4_rd0_vld", rd0_vld, 1);
        chk("t4_rd0_dat", rd0_dat, 6'h15);

        // 5. Async reset at clr_cnt=20, then a fresh complete sweep
        next_cycle();
        clr_start = 1'b1;
        clr_val   = 6'h2B;
        #1;
        for (int i = 0; i <= 20; i++) begin
            next_cycle();
            clr_start = 1'b0;
            #1;
        end
        chk("t5_adr_20", ram_adr, 20);
        chk("t5_busy_20", clr_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_wr_ena", ram_wr_ena, 1);
        chk("t5_rst_rd_ena", ram_rd_ena, 1);
        chk("t5_rst_busy", clr_busy, 0);
        chk("t5_rst_adr", ram_adr, 0);
        next_cycle();
        #1;
        chk("t5_rst_done", clr_done, 0);
        rst_n = 1'b1;
        next_cycle();
        #1;
        chk("t5_no_done", clr_done, 0);
        chk("t5_idle_wr_ena", ram_wr_ena, 1);
        clr_start = 1'b1;
        clr_val   = 6'h0C;
        busy_cnt  = 0;
        for (int i = 0; i < 70; i++) begin
            next_cycle();
            clr_start = 1'b0;
            #1;
            if (clr_busy) busy_cnt++;
            if (clr_done) begin
                chk("t5_done_at", i, 64);
                break;
            end
        end
        chk("t5_busy_cycles", busy_cnt, 64);
        chk("t5_done_seen", clr_done, 1);
        next_cycle();
        rd1_req = 1'b1;
        rd1_adr = 6'd30;
        #1;
        chk("t5_rd1_ack", rd1_ack, 1);
        next_cycle();
        rd1_req = 1'b0;
        #1;
        chk("t5_rd1_dat", rd1_dat, 6'h0C);

        idle_inputs();
        next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
